// File: rtl/cpu_clk_ctrl_if.sv
// Board-side control and strobe bundle for cpu_clk_ctrl.
// master: board/platform driving mode and button; slave: the clock controller.
interface cpu_clk_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       mode;
  logic             step_btn;
  logic [CNT_W-1:0] run_count;
  logic             cpu_en;
  logic             mem_en;
  logic             busy;
  logic             done;
  logic [31:0]      cycle_cnt;

  modport master (
    output mode, step_btn, run_count,
    input  cpu_en, mem_en, busy, done, cycle_cnt
  );

  modport slave (
    input  mode, step_btn, run_count,
    output cpu_en, mem_en, busy, done, cycle_cnt
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU/data-memory clock-enable generator with run/halt/step/run-N modes and a debounced step button.
// Optional issued-instruction counter on cycle_cnt: define CPU_CLK_CTRL_CYCLE_CNT_EN.
module cpu_clk_ctrl #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned MEM_PHASE  = 2,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  cpu_clk_ctrl_if.slave bus
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  if (DIV < 2 || DIV > 255 || MEM_PHASE < 1 || MEM_PHASE > DIV - 1 || DEB_CYCLES < 1) begin : g_bad_params
    $fatal(1, "cpu_clk_ctrl: illegal DIV/MEM_PHASE/DEB_CYCLES");
  end

  typedef enum logic [1:0] {MODE_HALT, MODE_RUN, MODE_STEP, MODE_RUN_N} mode_e;
  typedef enum logic [2:0] {IDLE, RUN, STEP, COUNT, DONE} state_e;

  mode_e            mode;
  state_e           state_q, state_d;
  logic [7:0]       phase_q;
  logic [CNT_W-1:0] remaining_q;
  logic             sync1_q, sync2_q, deb_level_q, deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             step_req, busy, period_end, cpu_en, mem_en;

  assign mode = mode_e'(bus.mode);

  // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q    <= bus.step_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_level_q;
      if (sync2_q == deb_level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_level_q <= sync2_q;
        deb_cnt_q   <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign step_req   = deb_level_q & ~deb_prev_q;
  assign busy       = (state_q == RUN) || (state_q == STEP) || (state_q == COUNT);
  assign period_end = busy && (phase_q == 8'(DIV - 1));
  assign cpu_en     = busy && (phase_q == 8'd0);
  assign mem_en     = busy && (phase_q == 8'(MEM_PHASE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mode == MODE_RUN)                   state_d = RUN;
        else if (mode == MODE_STEP && step_req) state_d = STEP;
        else if (mode == MODE_RUN_N)            state_d = (bus.run_count != '0) ? COUNT : DONE;
      end
      RUN:   if (period_end && mode != MODE_RUN) state_d = IDLE;
      STEP:  if (period_end) state_d = IDLE;
      COUNT: begin
        if (period_end) begin
          if (mode != MODE_RUN_N)        state_d = IDLE;
          else if (remaining_q == '0)    state_d = DONE;
        end
      end
      DONE:    if (mode != MODE_RUN_N) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= (busy && !period_end) ? phase_q + 8'd1 : 8'd0;
      if (state_q == IDLE && state_d == COUNT) remaining_q <= bus.run_count;
      else if (state_q == COUNT && cpu_en)     remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  assign bus.cpu_en = cpu_en;
  assign bus.mem_en = mem_en;
  assign bus.busy   = busy;
  assign bus.done   = (state_q == DONE);

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)       cycle_cnt_q <= '0;
    else if (cpu_en) cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`else
  assign bus.cycle_cnt = '0;
`endif

endmodule
